// File: rtl/dmac_channel_sequencer.sv
// Control sequencer for the two-channel DMAC datapath. It arbitrates peripheral
// requests, runs the CPU config handshake, owns the AHB master request and retires each transfer.
module dmac_channel_sequencer #(
    parameter bit          RR_EN    = 1'b1,
    parameter int unsigned TO_W     = 16,
    parameter int unsigned TO_LIMIT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] dma_req,
    input  logic       c_config,
    input  logic       irq,
    input  logic       hgrant,
    input  logic [1:0] m_hresp,
    output logic       hbusreq,
    output logic       channel_en_1,
    output logic       channel_en_2,
    output logic       con_sel,
    output logic       con_en,
    output logic       cfg_req,
    output logic       req_id,
    output logic [1:0] dma_ack,
    output logic       err_irq,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_BUSREQ,
        S_XFER,
        S_DONE,
        S_ABORT
    } state_e;

    localparam logic [1:0]      HRESP_ERROR = 2'b01;
    localparam logic [TO_W-1:0] WD_LAST     = TO_W'(TO_LIMIT - 1);

    state_e          state_q, state_d;
    logic            sel_q, sel_d;
    logic            last_grant_q;
    logic [TO_W-1:0] wd_q;
    logic            winner;

    logic            hbusreq_q, ch1_q, ch2_q, con_en_q, cfg_req_q, err_q, busy_q;
    logic [1:0]      ack_q;

    // Round-robin only matters on a tie; a lone request is always taken.
    assign winner = (RR_EN && (&dma_req)) ? ~last_grant_q : ~dma_req[0];

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (|dma_req) begin
                    state_d = S_CFG;
                    sel_d   = winner;
                end
            end
            S_CFG: begin
                if (!dma_req[sel_q]) begin
                    state_d = S_IDLE;
                end else if (c_config) begin
                    state_d = S_BUSREQ;
                end
            end
            S_BUSREQ: begin
                if (hgrant) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (irq) begin
                    state_d = S_DONE;
                end else if (m_hresp == HRESP_ERROR) begin
                    state_d = S_ABORT;
                end else if (wd_q == WD_LAST) begin
                    state_d = S_ABORT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            wd_q         <= '0;
            hbusreq_q    <= 1'b0;
            ch1_q        <= 1'b0;
            ch2_q        <= 1'b0;
            con_en_q     <= 1'b0;
            cfg_req_q    <= 1'b0;
            ack_q        <= 2'b00;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            state_q   <= state_d;
            sel_q     <= sel_d;
            con_en_q  <= (state_q == S_IDLE) && (state_d == S_CFG);
            cfg_req_q <= (state_d == S_CFG);
            hbusreq_q <= (state_d == S_BUSREQ) || (state_d == S_XFER);
            ch1_q     <= (state_d == S_XFER) && !sel_d;
            ch2_q     <= (state_d == S_XFER) && sel_d;
            ack_q     <= (state_d == S_DONE) ? (sel_d ? 2'b10 : 2'b01) : 2'b00;
            err_q     <= (state_d == S_ABORT);
            busy_q    <= (state_d != S_IDLE);

            if (state_q == S_XFER) begin
                wd_q <= wd_q + TO_W'(1);
            end else begin
                wd_q <= '0;
            end

            if ((state_q == S_DONE) || (state_q == S_ABORT)) begin
                last_grant_q <= sel_q;
            end
        end
    end

    assign hbusreq      = hbusreq_q;
    assign channel_en_1 = ch1_q;
    assign channel_en_2 = ch2_q;
    assign con_sel      = sel_q;
    assign req_id       = sel_q;
    assign con_en       = con_en_q;
    assign cfg_req      = cfg_req_q;
    assign dma_ack      = ack_q;
    assign err_irq      = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_dmac_channel_sequencer.sv
// Directed bench for dmac_channel_sequencer: a round-robin instance with a 32-cycle
// watchdog and a fixed-priority instance with an 8-cycle watchdog.
module tb_dmac_channel_sequencer;

    typedef struct packed {
        logic [1:0] dma_req;
        logic       c_config;
        logic       irq;
        logic       hgrant;
        logic [1:0] m_hresp;
    } in_t;

    typedef struct packed {
        logic       busy;
        logic       cfg_req;
        logic       con_en;
        logic       con_sel;
        logic       req_id;
        logic       hbusreq;
        logic       ch1;
        logic       ch2;
        logic [1:0] dma_ack;
        logic       err_irq;
    } out_t;

    typedef struct packed {
        in_t  stim;
        out_t want;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    in_t  in0, in1;
    out_t out0, out1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    logic       busy0, cfg0, cen0, csel0, rid0, hb0, e10, e20, err0;
    logic [1:0] ack0;
    logic       busy1, cfg1, cen1, csel1, rid1, hb1, e11, e21, err1;
    logic [1:0] ack1;

    dmac_channel_sequencer #(.RR_EN(1'b1), .TO_W(16), .TO_LIMIT(32)) dut_rr (
        .clk(clk), .rst(rst), .dma_req(in0.dma_req), .c_config(in0.c_config),
        .irq(in0.irq), .hgrant(in0.hgrant), .m_hresp(in0.m_hresp),
        .hbusreq(hb0), .channel_en_1(e10), .channel_en_2(e20), .con_sel(csel0),
        .con_en(cen0), .cfg_req(cfg0), .req_id(rid0), .dma_ack(ack0),
        .err_irq(err0), .busy(busy0)
    );

    dmac_channel_sequencer #(.RR_EN(1'b0), .TO_W(16), .TO_LIMIT(8)) dut_fp (
        .clk(clk), .rst(rst), .dma_req(in1.dma_req), .c_config(in1.c_config),
        .irq(in1.irq), .hgrant(in1.hgrant), .m_hresp(in1.m_hresp),
        .hbusreq(hb1), .channel_en_1(e11), .channel_en_2(e21), .con_sel(csel1),
        .con_en(cen1), .cfg_req(cfg1), .req_id(rid1), .dma_ack(ack1),
        .err_irq(err1), .busy(busy1)
    );

    assign out0 = {busy0, cfg0, cen0, csel0, rid0, hb0, e10, e20, ack0, err0};
    assign out1 = {busy1, cfg1, cen1, csel1, rid1, hb1, e11, e21, ack1, err1};

    function automatic out_t get_out(input int d);
        return (d == 0) ? out0 : out1;
    endfunction

    task automatic put(input int d, input in_t v);
        if (d == 0) in0 = v;
        else        in1 = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual === required) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, actual, required);
    endtask

    function automatic in_t mk_in(input logic [1:0] req, input logic cfg, input logic irq_v,
                                  input logic gnt, input logic [1:0] resp);
        in_t v;
        v.dma_req  = req;
        v.c_config = cfg;
        v.irq      = irq_v;
        v.hgrant   = gnt;
        v.m_hresp  = resp;
        return v;
    endfunction

    // Runs request -> CFG -> BUSREQ -> first XFER cycle; ok drops on any missed step.
    task automatic start_xfer(input int d, input logic [1:0] req, output logic sel, output logic ok);
        out_t o;
        ok  = 1'b0;
        sel = 1'b0;
        put(d, mk_in(req, 1'b0, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i < 10; i++) begin
            tick();
            o = get_out(d);
            if (o.con_en) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            sel = o.con_sel;
            put(d, mk_in(req, 1'b1, 1'b0, 1'b0, 2'b00));
            tick();
            put(d, mk_in(req, 1'b0, 1'b0, 1'b1, 2'b00));
            tick();
            o = get_out(d);
            if (!(o.hbusreq && (o.ch1 || o.ch2))) ok = 1'b0;
        end
    endtask

    task automatic serve(input int d, input logic [1:0] req, input int n_xfer, input logic irq_last,
                         input logic [1:0] resp_last, output logic sel, output out_t fin,
                         output out_t post, output logic ok);
        fin  = '0;
        post = '0;
        start_xfer(d, req, sel, ok);
        if (ok) begin
            for (int i = 1; i < n_xfer; i++) begin
                put(d, mk_in(req, 1'b0, 1'b0, 1'b1, 2'b00));
                tick();
            end
            put(d, mk_in(req, 1'b0, irq_last, 1'b1, resp_last));
            tick();
            fin = get_out(d);
            put(d, mk_in(req, 1'b0, 1'b0, 1'b0, 2'b00));
            tick();
            post = get_out(d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        vec_t vq[$];
        out_t o, fin, post;
        logic sel, ok, hb_seen;
        int   cnt;

        rst = 1'b1;
        in0 = '0;
        in1 = '0;
        tick();
        tick();
        check("reset_rr", get_out(0), 0);
        check("reset_fp", get_out(1), 0);
        rst = 1'b0;

        // Single ch1 transfer: config after 3 CFG cycles, grant 2 cycles later, irq ends the 10th XFER cycle.
        vq.push_back('{mk_in(2'b01, 0, 0, 0, 2'b00), out_t'{busy: 1, cfg_req: 1, con_en: 1, default: 0}});
        vq.push_back('{mk_in(2'b01, 0, 0, 0, 2'b00), out_t'{busy: 1, cfg_req: 1, default: 0}});
        vq.push_back('{mk_in(2'b01, 0, 0, 0, 2'b00), out_t'{busy: 1, cfg_req: 1, default: 0}});
        vq.push_back('{mk_in(2'b01, 1, 0, 0, 2'b00), out_t'{busy: 1, hbusreq: 1, default: 0}});
        vq.push_back('{mk_in(2'b01, 0, 0, 0, 2'b00), out_t'{busy: 1, hbusreq: 1, default: 0}});
        for (int i = 0; i < 10; i++)
            vq.push_back('{mk_in(2'b01, 0, 0, 1, 2'b00), out_t'{busy: 1, hbusreq: 1, ch1: 1, default: 0}});
        vq.push_back('{mk_in(2'b01, 0, 1, 1, 2'b00), out_t'{busy: 1, dma_ack: 2'b01, default: 0}});
        vq.push_back('{mk_in(2'b00, 0, 0, 0, 2'b00), out_t'{default: 0}});
        vq.push_back('{mk_in(2'b00, 0, 0, 0, 2'b00), out_t'{default: 0}});
        for (int i = 0; i < vq.size(); i++) begin
            put(0, vq[i].stim);
            tick();
            check($sformatf("single_vec%0d", i), get_out(0), vq[i].want);
        end

        // Round-robin contention from a fresh reset: ch1, ch2, ch1, ch2.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serve(0, 2'b11, 2, 1'b1, 2'b00, sel, fin, post, ok);
            check($sformatf("rr_ok%0d", i), ok, 1);
            check($sformatf("rr_sel%0d", i), sel, i % 2);
            check($sformatf("rr_ack%0d", i), fin.dma_ack, (i % 2 == 1) ? 2'b10 : 2'b01);
            check($sformatf("rr_idle_gap%0d", i), post.busy, 0);
        end
        put(0, '0);
        tick();

        // Fixed priority always serves ch1 under contention.
        for (int i = 0; i < 3; i++) begin
            serve(1, 2'b11, 2, 1'b1, 2'b00, sel, fin, post, ok);
            check($sformatf("fp_ok%0d", i), ok, 1);
            check($sformatf("fp_sel%0d", i), sel, 0);
            check($sformatf("fp_ack%0d", i), fin.dma_ack, 2'b01);
        end
        put(1, '0);
        tick();

        // Bus error aborts; irq in the same cycle wins over the error.
        serve(0, 2'b01, 3, 1'b0, 2'b01, sel, fin, post, ok);
        check("berr_ok", ok, 1);
        check("berr_err", fin.err_irq, 1);
        check("berr_ack", fin.dma_ack, 0);
        check("berr_en_drop", {fin.hbusreq, fin.ch1, fin.ch2}, 0);
        check("berr_err_pulse", post.err_irq, 0);
        serve(0, 2'b01, 3, 1'b1, 2'b01, sel, fin, post, ok);
        check("irq_win_ok", ok, 1);
        check("irq_win_ack", fin.dma_ack, 2'b01);
        check("irq_win_err", fin.err_irq, 0);
        put(0, '0);
        tick();

        // Watchdog limit 8: abort after exactly 8 XFER cycles.
        start_xfer(1, 2'b01, sel, ok);
        check("wd_start", ok, 1);
        cnt = 1;
        o   = '0;
        for (int i = 0; i < 40; i++) begin
            put(1, mk_in(2'b01, 1'b0, 1'b0, 1'b1, 2'b00));
            tick();
            o = get_out(1);
            if (o.err_irq) break;
            if (o.ch1) cnt++;
        end
        check("wd_err", o.err_irq, 1);
        check("wd_cycles", cnt, 8);
        check("wd_ack", o.dma_ack, 0);
        check("wd_en_drop", o.ch1, 0);
        put(1, '0);
        tick();
        check("wd_busy_after", get_out(1).busy, 0);

        // Cancel in CFG: request dropped before config.
        put(0, mk_in(2'b10, 1'b0, 1'b0, 1'b0, 2'b00));
        ok = 1'b0;
        hb_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            o = get_out(0);
            hb_seen |= o.hbusreq;
            if (o.con_en) begin
                ok = 1'b1;
                break;
            end
        end
        check("cancel_con_en", ok, 1);
        check("cancel_sel", o.con_sel, 1);
        check("cancel_cfg_req", o.cfg_req, 1);
        put(0, '0);
        tick();
        o = get_out(0);
        check("cancel_idle", {o.busy, o.dma_ack, o.err_irq}, 0);
        hb_seen |= o.hbusreq;
        tick();
        hb_seen |= get_out(0).hbusreq;
        check("cancel_no_busreq", hb_seen, 0);

        // Reset mid-XFER clears everything and restores ch1-first arbitration.
        start_xfer(0, 2'b11, sel, ok);
        check("rst_mid_start", ok, 1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_outputs", get_out(0), 0);
        rst = 1'b0;
        tick();
        o = get_out(0);
        check("rst_mid_rearb", {o.con_en, o.con_sel}, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmac_channel_sequencer.md
Name: dmac_channel_sequencer

Overview:
- Control FSM that sequences the two-channel DMAC datapath: arbitrates peripheral DMA requests and requests CPU configuration of the shared register set.
- Acquires the AHB master bus, enables the selected channel and drives the channel mux select, then retires the transfer on completion, bus error or watchdog timeout.
- Sits beside the DMAC datapath; drives its channel_en_1/2, con_en and con_sel inputs and consumes its C_config and irq outputs.

Parameters:
- RR_EN, 1, 0 = fixed priority (dma_req[0] wins), 1 = round-robin between the two requesters
- TO_W, 16, width of the transfer watchdog counter
- TO_LIMIT, 16'hFFFF, XFER cycles before forced abort; must fit in TO_W bits

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- dma_req  in  2  level requests from peripherals; bit i maps to channel i+1
- c_config  in  1  CPU has written a control word with bit 16 set (datapath C_config)
- irq  in  1  transfer complete from datapath
- hgrant  in  1  AHB bus grant for the DMAC master
- m_hresp  in  2  AHB master response; 2'b01 = ERROR
- hbusreq  out  1  AHB bus request
- channel_en_1  out  1  enable to channel 1
- channel_en_2  out  1  enable to channel 2
- con_sel  out  1  registered channel select (0 = ch1, 1 = ch2)
- con_en  out  1  one-cycle pulse; datapath latches con_sel
- cfg_req  out  1  interrupt to CPU: program registers for channel req_id
- req_id  out  1  index of the channel being served
- dma_ack  out  2  one-cycle done pulse to the requesting peripheral
- err_irq  out  1  one-cycle pulse on abort
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = 1, watchdog = 0. Reset mid-transfer drops channel_en and hbusreq on the next edge; no ack is issued.
- States: IDLE, CFG, BUSREQ, XFER, DONE, ABORT. All outputs are registered or decoded from state plus registered sel.
- IDLE, with any dma_req bit set:
  - Choose winner. Fixed priority: bit 0 wins. RR: if both bits are set, take the index != last_grant; if one is set, take it.
  - Register sel into con_sel and req_id, pulse con_en for 1 cycle, go to CFG.
  - Winner-to-con_en latency is 1 cycle.
- CFG:
  - cfg_req = 1.
  - dma_req[sel] = 0 → IDLE (cancel; no ack, no err, last_grant unchanged).
  - Otherwise, c_config = 1 → BUSREQ.
  - Cancel has priority if both conditions occur in the same cycle.
- BUSREQ: hbusreq = 1; hgrant = 1 → XFER.
- XFER:
  - hbusreq = 1, channel_en_(sel+1) = 1; the other enable stays 0. The enables are never both high.
  - Watchdog clears on entry and increments each XFER cycle.
  - Priority among exit events: irq → DONE; else m_hresp = 2'b01 → ABORT; else watchdog == TO_LIMIT-1 → ABORT.
  - Requests arriving in XFER are ignored until IDLE.
  - The fabric holds hgrant while hbusreq is high; the sequencer does not react to grant loss.
- DONE: dma_ack[sel] = 1 for 1 cycle, last_grant <= sel → IDLE. channel_en and hbusreq are 0 in DONE.
- ABORT: err_irq = 1 for 1 cycle, no dma_ack, last_grant <= sel → IDLE.
- A request still held high after DONE/ABORT is re-arbitrated in IDLE. This gives a minimum of 1 idle cycle between transfers.
- con_sel holds its value between transfers; it changes only on a con_en cycle.

Test Plan:
- Single request: dma_req=01, c_config=1 after 3 cycles, hgrant 2 cycles later, irq after 10 XFER cycles → con_en pulse with con_sel=0; cfg_req high through CFG; channel_en_1 high exactly 10 cycles; channel_en_2 never high; dma_ack=01 for 1 cycle; busy=0 afterwards.
- Contention, RR_EN=1: dma_req=11 held, each transfer completed by irq → served order ch1, ch2, ch1, ch2 (con_sel 0,1,0,1). With RR_EN=0 → ch1 served every time.
- Bus error: in XFER, m_hresp=01 with irq=0 → next state ABORT; err_irq=1 for 1 cycle; dma_ack=00; channel_en drops. Repeat with irq=1 and m_hresp=01 in the same cycle → DONE, ack, no err_irq.
- Watchdog with TO_LIMIT=8 and irq never asserted → abort after exactly 8 XFER cycles; err_irq pulse; busy=0 one cycle later.
- Cancel: dma_req[1] only, dropped while in CFG (c_config=0) → return to IDLE; no ack, no err; hbusreq never asserted.
- Reset mid-XFER (rst=1 for 1 cycle) → next edge: all outputs 0 and state IDLE; with dma_req=11, RR_EN=1 → ch1 is chosen first.
